tap_mac_serial: RTL

// Serial multiply-accumulate FIR stage of the adaptive filter datapath.
// - Holds a TAPS-deep sample delay line and a TAPS-entry coefficient register file.
// - For each accepted sample, computes y = sum(c[k]*x[k]), one tap per clock.
// - Result sits directly upstream of memory_16bit: y_out drives its d, y_valid drives its enable.

---
 rtl/tap_mac_serial.sv | 133 +++++++++++++
 1 files changed

// File: rtl/tap_mac_serial.sv
// rtl/tap_mac_serial.sv - serial multiply-accumulate FIR stage, one tap per clock
// Optional output saturation: define TAP_MAC_SAT_EN (default build wraps to OW bits).
module tap_mac_serial #(
    parameter int TAPS = 4,
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int OW   = 16,
    localparam int AW   = $clog2(TAPS),
    localparam int ACCW = DW + CW + $clog2(TAPS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic signed [DW-1:0] sample_in,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    input  logic                 coef_wr,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic [OW-1:0]        y_out,
    output logic                 y_valid,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [DW-1:0]    x_q [TAPS];
    logic signed [CW-1:0]    c_q [TAPS];
    logic signed [ACCW-1:0]  acc_q;
    logic [AW-1:0]           tap_q;
    logic [OW-1:0]           y_out_q;

    logic                    accept;
    logic                    last_tap;
    logic signed [DW+CW-1:0] prod;
    logic signed [ACCW-1:0]  acc_next;
    logic [OW-1:0]           y_red;

    assign last_tap = (tap_q == AW'(TAPS - 1));
    assign prod     = x_q[tap_q] * c_q[tap_q];
    assign acc_next = acc_q + {{(ACCW-DW-CW){prod[DW+CW-1]}}, prod};

`ifdef TAP_MAC_SAT_EN
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((1 << (OW - 1)) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        y_red = acc_next[OW-1:0];
        if (acc_next > SAT_MAX) begin
            y_red = SAT_MAX[OW-1:0];
        end else if (acc_next < SAT_MIN) begin
            y_red = SAT_MIN[OW-1:0];
        end
    end
`else
    assign y_red = acc_next[OW-1:0];
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sample_ready = 1'b0;
        y_valid      = 1'b0;
        accept       = 1'b0;
        case (state_q)
            IDLE: begin
                sample_ready = 1'b1;
                if (sample_valid) begin
                    accept  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (last_tap) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                y_valid = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // y_out is loaded on the final MAC edge so it is already new while y_valid is high in OUT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                c_q[k] <= '0;
            end
            acc_q   <= '0;
            tap_q   <= '0;
            y_out_q <= '0;
        end else begin
            if (state_q == IDLE && coef_wr && (int'(coef_addr) < TAPS)) begin
                c_q[coef_addr] <= coef_data;
            end
            if (accept) begin
                for (int k = TAPS - 1; k > 0; k--) begin
                    x_q[k] <= x_q[k-1];
                end
                x_q[0] <= sample_in;
                acc_q  <= '0;
                tap_q  <= '0;
            end
            if (state_q == MAC) begin
                acc_q <= acc_next;
                tap_q <= tap_q + AW'(1);
                if (last_tap) begin
                    y_out_q <= y_red;
                end
            end
        end
    end

    assign y_out = y_out_q;
    assign busy  = ~sample_ready;

endmodule
